cache_dm_wt: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate cache between the CPU load/store port and word-wide main memory.
- Adds tag/valid tracking, line refill with an explicit memory handshake and a CPU valid/ready handshake.
- Line size and set count are generic.
- Instantiated in the memory stage in place of the fixed-size cache.

---
 rtl/cache_pkg.sv | 48 ++++
 rtl/cache_dm_wt_if.sv | 39 +++
 rtl/cache_tag_store.sv | 46 ++++
 rtl/cache_dm_wt.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cache_dm_wt.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, constants and address helpers for the direct-mapped
// write-through cache.
package cache_pkg;

  localparam int DATA_W = 32;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REFILL = 3'd2,
    ST_RESP   = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  // Tag width left over once index and offset bits are removed
  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // Words per line
  function automatic int calc_wpl(input int offset_w);
    return 32'sd1 << (offset_w - 2);
  endfunction

  // Width of the word counter; one bit minimum so single-word lines still work
  function automatic int calc_cnt_w(input int offset_w);
    return (offset_w > 2) ? (offset_w - 2) : 1;
  endfunction

  // Tag field of a byte address
  function automatic logic [63:0] field_tag(input logic [63:0] addr, input int index_w,
                                            input int offset_w);
    return addr >> (index_w + offset_w);
  endfunction

  // Set index field of a byte address
  function automatic logic [63:0] field_index(input logic [63:0] addr, input int index_w,
                                              input int offset_w);
    return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
  endfunction

  // Word offset within the line (zero for single-word lines)
  function automatic logic [63:0] field_word(input logic [63:0] addr, input int offset_w);
    return (addr >> 2) & ((64'd1 << (offset_w - 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_dm_wt_if.sv
// CPU load/store handshake and word-wide memory handshake of the cache.
// slave: the cache itself; master: the CPU/memory environment around it.
interface cache_dm_wt_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_wdone;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cache_tag_store.sv
// Valid + tag array: valid bits clear in one cycle on reset, one
// combinational read port and one write port that also sets the valid bit.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_ram [0:LINES-1];

  // Valid bits: wiped by reset, set when a line finishes refilling
  always_ff @(posedge clk) begin
    if (!clr) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag storage: contents are don't-care until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (clr && wr_en) begin
      tag_ram[wr_index] <= wr_tag;
    end
  end

  // Read port
  always_comb begin
    rd_valid = valid_r[rd_index];
    rd_tag   = tag_ram[rd_index];
  end

endmodule

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache.
// Optional build macro CACHE_STATS_EN adds saturating hit_cnt / miss_cnt
// outputs counting lookup outcomes.
module cache_dm_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic clk,
  input  logic clr,
  cache_dm_wt_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WPL    = calc_wpl(OFFSET_W);
  localparam int CNT_W  = calc_cnt_w(OFFSET_W);
  localparam int RAM_AW = INDEX_W + CNT_W;

  state_t state_r, state_nxt;

  // Request latched at acceptance
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;

  // Refill word counter
  logic [CNT_W-1:0] cnt_r, cnt_nxt, cnt_inc_s;
  logic             last_s;

  // Registered outputs and their next values
  logic              cpu_ready_r, cpu_ready_s;
  logic              cpu_rvalid_r, cpu_rvalid_s;
  logic              cpu_wdone_r, cpu_wdone_s;
  logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

  // Address decode of the latched request
  logic [TAG_W-1:0]   tag_s;
  logic [INDEX_W-1:0] idx_s;
  logic [CNT_W-1:0]   word_s;
  logic [ADDR_W-1:0]  line_base_s;
  logic [ADDR_W-1:0]  word_addr_s;

  // Tag store interface
  logic             tag_valid_s;
  logic [TAG_W-1:0] tag_rd_s;
  logic             tag_we_s;
  logic             hit_s;

  // Data RAM, addressed as {index, word}
  logic [DATA_W-1:0] data_ram [0:(1 << RAM_AW)-1];
  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] rd_word_s;

  // Field extraction from the latched address
  always_comb begin
    tag_s       = TAG_W'(field_tag(64'(addr_r), INDEX_W, OFFSET_W));
    idx_s       = INDEX_W'(field_index(64'(addr_r), INDEX_W, OFFSET_W));
    word_s      = CNT_W'(field_word(64'(addr_r), OFFSET_W));
    line_base_s = {addr_r[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    word_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
    cnt_inc_s   = cnt_r + CNT_W'(1);
    last_s      = (cnt_r == CNT_W'(WPL - 1));
    hit_s       = tag_valid_s && (tag_rd_s == tag_s);
    rd_word_s   = data_ram[{idx_s, word_s}];
  end

  cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk      (clk),
    .clr      (clr),
    .rd_index (idx_s),
    .rd_valid (tag_valid_s),
    .rd_tag   (tag_rd_s),
    .wr_en    (tag_we_s),
    .wr_index (idx_s),
    .wr_tag   (tag_s)
  );

  // Data RAM write port: store hits and refill words; suppressed during reset
  always_ff @(posedge clk) begin
    if (clr && ram_we_s) begin
      data_ram[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Capture the CPU request when it is accepted in IDLE
  always_ff @(posedge clk) begin
    if (!clr) begin
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
    end else if (state_r == ST_IDLE && bus.cpu_req) begin
      addr_r  <= bus.cpu_addr;
      we_r    <= bus.cpu_we;
      wdata_r <= bus.cpu_wdata;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state_r;
    cnt_nxt      = cnt_r;
    cpu_rvalid_s = 1'b0;
    cpu_wdone_s  = 1'b0;
    cpu_rdata_s  = cpu_rdata_r;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    ram_we_s     = 1'b0;
    ram_waddr_s  = {idx_s, word_s};
    ram_wdata_s  = wdata_r;
    tag_we_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_nxt = ST_LOOKUP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (we_r) begin
          // Write-through: update the line only on a hit, always write memory
          if (hit_s) begin
            ram_we_s = 1'b1;
          end else begin
            ram_we_s = 1'b0;
          end
          state_nxt   = ST_WRITE;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b1;
          mem_addr_s  = word_addr_s;
          mem_wdata_s = wdata_r;
        end else if (hit_s) begin
          cpu_rdata_s  = rd_word_s;
          cpu_rvalid_s = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          state_nxt  = ST_REFILL;
          cnt_nxt    = '0;
          mem_req_s  = 1'b1;
          mem_we_s   = 1'b0;
          mem_addr_s = line_base_s;
        end
      end
      ST_REFILL: begin
        if (mem_req_r && bus.mem_ack) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = {idx_s, cnt_r};
          ram_wdata_s = bus.mem_rdata;
          if (last_s) begin
            tag_we_s  = 1'b1;
            state_nxt = ST_RESP;
            mem_req_s = 1'b0;
            mem_we_s  = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt    = cnt_inc_s;
            mem_addr_s = line_base_s | ADDR_W'({cnt_inc_s, 2'b00});
          end
        end else begin
          state_nxt = ST_REFILL;
        end
      end
      ST_RESP: begin
        cpu_rdata_s  = rd_word_s;
        cpu_rvalid_s = 1'b1;
        state_nxt    = ST_IDLE;
      end
      ST_WRITE: begin
        if (mem_req_r && bus.mem_ack) begin
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          cpu_wdone_s = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
    cpu_ready_s = (state_nxt == ST_IDLE);
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      cpu_ready_r  <= 1'b1;
      cpu_rvalid_r <= 1'b0;
      cpu_wdone_r  <= 1'b0;
      cpu_rdata_r  <= '0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      cpu_ready_r  <= cpu_ready_s;
      cpu_rvalid_r <= cpu_rvalid_s;
      cpu_wdone_r  <= cpu_wdone_s;
      cpu_rdata_r  <= cpu_rdata_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
    end
  end

  assign bus.cpu_ready  = cpu_ready_r;
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.cpu_wdone  = cpu_wdone_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Saturating lookup-outcome counters
  always_ff @(posedge clk) begin
    if (!clr) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else if (state_r == ST_LOOKUP) begin
      if (hit_s) begin
        if (hit_cnt_r != 32'hFFFF_FFFF) begin
          hit_cnt_r <= hit_cnt_r + 32'd1;
        end
      end else begin
        if (miss_cnt_r != 32'hFFFF_FFFF) begin
          miss_cnt_r <= miss_cnt_r + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_dm_wt.sv
// Directed bench for cache_dm_wt with a word-wide memory responder model.
module tb_cache_dm_wt;

  logic clk;
  logic clr;

  cache_dm_wt_if #(.ADDR_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_dm_wt #(
    .ADDR_W   (32),
    .INDEX_W  (8),
    .OFFSET_W (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_checks;
  int ack_cnt;

  logic [31:0] q_addr [$];
  logic        q_we [$];
  logic [31:0] q_wdata [$];
  logic [31:0] wmem [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Backing memory: stored words, else 0xA0+word (tag bit 20 clear) or 0xB0+word
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return (a[20] ? 32'h0000_00B0 : 32'h0000_00A0) + 32'(a[3:2]);
  endfunction

  // Memory responder: one ack per request, every other cycle
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    ack_cnt       = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req && clr) begin
        q_addr.push_back(bus.mem_addr);
        q_we.push_back(bus.mem_we);
        q_wdata.push_back(bus.mem_wdata);
        if (bus.mem_we) begin
          wmem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mem_val(bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        ack_cnt++;
      end
    end
  end

  // One CPU access; lat counts cycles from the acceptance cycle (=1) to the done pulse
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int q0,
                        output int nreq);
    logic done;
    @(negedge clk);
    check_eq("ready before req", 32'(bus.cpu_ready), 32'd1);
    q0            = q_addr.size();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    lat = 1;
    #1;
    bus.cpu_req = 1'b0;
    done  = 1'b0;
    rdata = 32'd0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (we ? bus.cpu_wdone : bus.cpu_rvalid) begin
        done  = 1'b1;
        rdata = bus.cpu_rdata;
      end
    end
    check_eq("op completed", 32'(done), 32'd1);
    nreq = q_addr.size() - q0;
  endtask

  task automatic check_refill(input string tag, input int q0, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, " addr"}, q_addr[q0+i], base + 32'(4*i));
      check_eq({tag, " we"}, 32'(q_we[q0+i]), 32'd0);
    end
  endtask

  initial begin : main
    logic [31:0] rd;
    int lat, q0, nreq, base;
    n_pass = 0;
    n_checks = 0;
    clr = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst cpu_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check_eq("rst cpu_wdone", 32'(bus.cpu_wdone), 32'd0);
    check_eq("rst mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst cpu_rdata", bus.cpu_rdata, 32'd0);
    check_eq("rst mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Cold miss with 4-word refill
    cpu_op(1'b0, 32'h0000_1234, 32'd0, rd, lat, q0, nreq);
    check_eq("miss1 rdata", rd, 32'h0000_00A1);
    check_eq("miss1 nreq", 32'(nreq), 32'd4);
    check_eq("miss1 latency", 32'(lat), 32'd10);
    check_refill("miss1", q0, 32'h0000_1230);

    // Hit in the same line
    cpu_op(1'b0, 32'h0000_123C, 32'd0, rd, lat, q0, nreq);
    check_eq("hit rdata", rd, 32'h0000_00A3);
    check_eq("hit nreq", 32'(nreq), 32'd0);
    check_eq("hit latency", 32'(lat), 32'd2);

    // Store hit: write-through to memory
    cpu_op(1'b1, 32'h0000_1238, 32'hDEAD_BEEF, rd, lat, q0, nreq);
    check_eq("st hit nreq", 32'(nreq), 32'd1);
    check_eq("st hit addr", q_addr[q0], 32'h0000_1238);
    check_eq("st hit we", 32'(q_we[q0]), 32'd1);
    check_eq("st hit wdata", q_wdata[q0], 32'hDEAD_BEEF);
    check_eq("st hit latency", 32'(lat), 32'd3);
    cpu_op(1'b0, 32'h0000_1238, 32'd0, rd, lat, q0, nreq);
    check_eq("ld after st rdata", rd, 32'hDEAD_BEEF);
    check_eq("ld after st nreq", 32'(nreq), 32'd0);

    // Conflict miss replaces the line, then the old tag misses again
    cpu_op(1'b0, 32'h0010_1234, 32'd0, rd, lat, q0, nreq);
    check_eq("conflict rdata", rd, 32'h0000_00B1);
    check_eq("conflict nreq", 32'(nreq), 32'd4);
    check_refill("conflict", q0, 32'h0010_1230);
    cpu_op(1'b0, 32'h0000_1234, 32'd0, rd, lat, q0, nreq);
    check_eq("remiss rdata", rd, 32'h0000_00A1);
    check_eq("remiss nreq", 32'(nreq), 32'd4);
    check_refill("remiss", q0, 32'h0000_1230);
    cpu_op(1'b0, 32'h0000_1238, 32'd0, rd, lat, q0, nreq);
    check_eq("refilled st word", rd, 32'hDEAD_BEEF);
    check_eq("refilled st nreq", 32'(nreq), 32'd0);

    // Store miss: no allocate
    cpu_op(1'b1, 32'h0000_5000, 32'h1234_5678, rd, lat, q0, nreq);
    check_eq("st miss nreq", 32'(nreq), 32'd1);
    check_eq("st miss addr", q_addr[q0], 32'h0000_5000);
    check_eq("st miss we", 32'(q_we[q0]), 32'd1);
    check_eq("st miss latency", 32'(lat), 32'd3);
    cpu_op(1'b0, 32'h0000_5000, 32'd0, rd, lat, q0, nreq);
    check_eq("ld after st miss nreq", 32'(nreq), 32'd4);
    check_eq("ld after st miss rdata", rd, 32'h1234_5678);
    check_refill("st miss fill", q0, 32'h0000_5000);

    // Reset in the middle of a refill
    base = ack_cnt;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0010_1234;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ack_cnt >= base + 2) break;
    end
    check_eq("abort ack count", 32'(ack_cnt - base), 32'd2);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("abort cpu_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("abort cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    cpu_op(1'b0, 32'h0010_1234, 32'd0, rd, lat, q0, nreq);
    check_eq("post abort rdata", rd, 32'h0000_00B1);
    check_eq("post abort nreq", 32'(nreq), 32'd4);
    check_refill("post abort", q0, 32'h0010_1230);
    cpu_op(1'b0, 32'h0000_5004, 32'd0, rd, lat, q0, nreq);
    check_eq("post rst other line nreq", 32'(nreq), 32'd4);
    check_eq("post rst other line rdata", rd, 32'h0000_00A1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
